exc_commit_ctrl: RTL
====================

Name: exc_commit_ctrl

Overview:
- Writeback-stage exception/interrupt/ERTN sequencer sitting between the WB stage and the CSR file.
- Prioritises exception causes for the committing instruction and gates CSR writes.
- Pulses the CSR file's exception/return strobes, drives the pipeline flush, and issues a single redirect (exception entry or ERA) to the fetch stage.
- Stalls WB while a flush/redirect sequence is in progress.

Parameters:
- FLUSH_MIN, 2, minimum number of cycles `flush` stays asserted (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_valid  in  1  WB holds an instruction
- ws_ready  out  1  WB may commit this cycle
- ws_pc  in  32  PC of WB instruction
- ws_vaddr  in  32  load/store address (ALE)
- ws_ex_vec  in  5  raw causes: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
- ws_ertn  in  1  instruction is ERTN
- ws_csr_we  in  1  instruction writes a CSR
- csr_we_out  out  1  gated CSR write enable to CSR file
- has_int  in  1  pending enabled interrupt from CSR file
- ex_entry  in  32  exception entry from CSR file
- ertn_entry  in  32  ERA from CSR file
- wb_ex  out  1  exception strobe to CSR file
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_csr_pc  out  32  PC recorded into ERA
- wb_vaddr  out  32  bad address for BADV
- ertn_flush  out  1  return strobe to CSR file
- flush  out  1  kill all younger pipeline stages
- pipe_empty  in  1  IF..MEM drained, no outstanding bus transaction
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- FSM states: IDLE, FLUSH, REDIRECT.
- Reset values: state IDLE; all outputs 0 except ws_ready=1; flush counter 0.
- ws_ready = 1 only in IDLE. A commit is `ws_valid & ws_ready`.
- Trigger on commit in IDLE. Take the first matching row:
  - has_int: INT, ecode 0x00, esub 0
  - ADEF: ecode 0x08, esub 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
  - ws_ertn: ERTN
  - otherwise: normal commit
  - esubcode is 0 for every cause.
- Exception or interrupt trigger (combinational in the commit cycle):
  - wb_ex=1 for exactly that cycle.
  - wb_ecode/wb_esubcode as above; wb_csr_pc=ws_pc; wb_vaddr=ws_vaddr.
  - csr_we_out=0.
  - Latch redirect_pc <= ex_entry.
  - Next state FLUSH.
- ERTN trigger: ertn_flush=1 for that cycle only; latch redirect_pc <= ertn_entry; csr_we_out=0; next state FLUSH.
- Normal commit: csr_we_out = ws_csr_we; state stays IDLE.
- wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, ertn_flush and csr_we_out are 0 whenever there is no trigger or commit.
- FLUSH:
  - flush=1; a 4-bit counter runs from 1.
  - Go to REDIRECT once counter >= FLUSH_MIN and pipe_empty=1, both sampled in the same cycle.
  - pipe_empty alone never shortens the FLUSH_MIN hold.
- REDIRECT:
  - flush=0, redirect_valid=1, redirect_pc stable.
  - Hold until redirect_ready=1, then go to IDLE in the next cycle.
  - No combinational path from redirect_ready to redirect_valid.
- has_int, ws_ex_vec and ws_ertn are ignored outside IDLE.
- redirect_pc is captured once at trigger and does not follow later ex_entry/ertn_entry changes.
- Simultaneous events:
  - INT and ERTN on the same instruction: INT wins; ertn_flush=0; ERA=ws_pc.
  - Multiple causes: only the highest-priority cause is reported.
  - CSR write with any exception: the write is suppressed.
- Reset in any state: IDLE next cycle; flush and redirect_valid are 0 from that edge.
- Trigger-to-flush latency: wb_ex/ertn_flush in cycle T; flush first high in T+1.

Decomposition:
- Package exc_defs:
  - ECODE_INT/ADE/ALE/SYS/BRK/INE constants.
  - ws_ex_vec bit indices.
  - FSM state encoding.
- Sub-module exc_prio_enc (combinational): {has_int, ws_ex_vec, ws_ertn} -> {is_ex, is_ertn, ecode, esubcode}.

Test Plan:
- Normal CSR write (ws_valid=1, ws_csr_we=1, no causes) -> csr_we_out=1 the same cycle; wb_ex=0; state stays IDLE; ws_ready stays 1.
- SYS at pc 0x1c000100, ex_entry=0x1c008000:
  - wb_ex pulse, ecode 0x0B, wb_csr_pc=0x1c000100.
  - flush high ≥2 cycles until pipe_empty.
  - redirect_pc=0x1c008000 held until redirect_ready.
- ADEF+ALE+SYS with has_int=1 -> ecode 0x00 only; ALE vaddr 0xdeadbeef on a lone-ALE case -> ecode 0x09, wb_vaddr=0xdeadbeef.
- ERTN with ertn_entry=0x1c000204:
  - ertn_flush single pulse, wb_ex=0.
  - redirect to 0x1c000204.
  - Changing ertn_entry during FLUSH does not alter redirect_pc.
- pipe_empty=1 from the start with FLUSH_MIN=3 -> flush exactly 3 cycles; pipe_empty held low 10 cycles -> flush 10 cycles, ws_ready=0 throughout.
- Reset asserted in REDIRECT with redirect_ready=0 -> next cycle redirect_valid=0, ws_ready=1, then a normal commit succeeds.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the writeback exception/ERTN commit controller:
// exception codes, raw-cause bit positions, FSM encoding and the cause record.
package exc_defs;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // bit positions inside ws_ex_vec
    localparam int EX_ADEF = 0;
    localparam int EX_INE  = 1;
    localparam int EX_SYS  = 2;
    localparam int EX_BRK  = 3;
    localparam int EX_ALE  = 4;
    localparam int EX_W    = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } exc_state_e;

    // prioritised result for the committing instruction
    typedef struct packed {
        logic       is_ex;
        logic       is_ertn;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } exc_cause_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB / CSR-file / fetch signals seen by the commit controller.
// master = the controller, slave = the surrounding pipeline.
interface exc_commit_ctrl_if;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic [4:0]  ws_ex_vec;
    logic        ws_ertn;
    logic        ws_csr_we;
    logic        csr_we_out;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        flush;
    logic        pipe_empty;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        input  ws_valid, ws_pc, ws_vaddr, ws_ex_vec, ws_ertn, ws_csr_we,
        input  has_int, ex_entry, ertn_entry, pipe_empty, redirect_ready,
        output ws_ready, csr_we_out, wb_ex, wb_ecode, wb_esubcode,
        output wb_csr_pc, wb_vaddr, ertn_flush, flush, redirect_valid, redirect_pc
    );

    modport slave (
        output ws_valid, ws_pc, ws_vaddr, ws_ex_vec, ws_ertn, ws_csr_we,
        output has_int, ex_entry, ertn_entry, pipe_empty, redirect_ready,
        input  ws_ready, csr_we_out, wb_ex, wb_ecode, wb_esubcode,
        input  wb_csr_pc, wb_vaddr, ertn_flush, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Cause priority encoder: interrupt > ADEF > INE > SYS > BRK > ALE > ERTN.
module exc_prio_enc
    import exc_defs::*;
(
    input  logic            has_int,
    input  logic [EX_W-1:0] ex_vec,
    input  logic            ertn,
    output exc_cause_t      cause
);

    // first matching row wins; esubcode is always zero
    always_comb begin
        cause = '0;
        if (has_int) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_INT;
        end else if (ex_vec[EX_ADEF]) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_ADE;
        end else if (ex_vec[EX_INE]) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_INE;
        end else if (ex_vec[EX_SYS]) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_SYS;
        end else if (ex_vec[EX_BRK]) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_BRK;
        end else if (ex_vec[EX_ALE]) begin
            cause.is_ex = 1'b1;
            cause.ecode = ECODE_ALE;
        end else if (ertn) begin
            cause.is_ertn = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback exception/interrupt/ERTN sequencer: strobes the CSR file,
// holds flush for at least FLUSH_MIN cycles until the pipe drains, then
// issues a single redirect to fetch. WB is stalled outside IDLE.
module exc_commit_ctrl
    import exc_defs::*;
#(
    parameter int FLUSH_MIN = 2
) (
    input  logic              clk,
    input  logic              reset,
    exc_commit_ctrl_if.master bus
);

    exc_state_e  state, state_nxt;
    logic [3:0]  flush_cnt;
    logic [31:0] redirect_pc_q;
    exc_cause_t  cause;
    logic        commit;
    logic        trig;

    exc_prio_enc u_prio (
        .has_int (bus.has_int),
        .ex_vec  (bus.ws_ex_vec),
        .ertn    (bus.ws_ertn),
        .cause   (cause)
    );

    // causes only count for an instruction that actually commits in IDLE
    assign commit = bus.ws_valid & (state == S_IDLE);
    assign trig   = commit & (cause.is_ex | cause.is_ertn);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state; the hold count and pipe_empty must agree in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (trig) state_nxt = S_FLUSH;
            S_FLUSH:    if ((flush_cnt >= 4'(FLUSH_MIN)) && bus.pipe_empty) state_nxt = S_REDIRECT;
            S_REDIRECT: if (bus.redirect_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // flush hold counter: 1 in the first FLUSH cycle, saturates at 15
    always_ff @(posedge clk) begin
        if (reset)                                     flush_cnt <= 4'd0;
        else if (state == S_FLUSH && flush_cnt != 4'hF) flush_cnt <= flush_cnt + 4'd1;
        else if (state == S_FLUSH)                     flush_cnt <= flush_cnt;
        else if (trig)                                 flush_cnt <= 4'd1;
        else                                           flush_cnt <= 4'd0;
    end

    // redirect target captured once at trigger, immune to later entry changes
    always_ff @(posedge clk) begin
        if (reset)     redirect_pc_q <= 32'd0;
        else if (trig) redirect_pc_q <= cause.is_ex ? bus.ex_entry : bus.ertn_entry;
    end

    // outputs: state-decoded controls plus commit-cycle CSR strobes
    always_comb begin
        bus.ws_ready       = (state == S_IDLE);
        bus.flush          = (state == S_FLUSH);
        bus.redirect_valid = (state == S_REDIRECT);
        bus.redirect_pc    = redirect_pc_q;
        bus.wb_ex          = 1'b0;
        bus.wb_ecode       = 6'd0;
        bus.wb_esubcode    = 9'd0;
        bus.wb_csr_pc      = 32'd0;
        bus.wb_vaddr       = 32'd0;
        bus.ertn_flush     = 1'b0;
        bus.csr_we_out     = 1'b0;
        if (commit) begin
            if (cause.is_ex) begin
                bus.wb_ex       = 1'b1;
                bus.wb_ecode    = cause.ecode;
                bus.wb_esubcode = cause.esubcode;
                bus.wb_csr_pc   = bus.ws_pc;
                bus.wb_vaddr    = bus.ws_vaddr;
            end else if (cause.is_ertn) begin
                bus.ertn_flush  = 1'b1;
            end else begin
                bus.csr_we_out  = bus.ws_csr_we;
            end
        end
    end

endmodule
